vga_timing_recovery: RTL and testbench

- Sink-side counterpart of the VGA timing generator. Samples incoming hsync, vsync and blank_b from a video source and recovers pixel coordinates x and y.
- Measures line and frame lengths against the nominal 640x480 timing and reports lock.
- Used by capture and overlay blocks that receive a video stream instead of generating one.

---
 rtl/vga_timing_recovery.sv | 218 +++++++++++++++++++++
 tb/tb_vga_timing_recovery.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_recovery.sv
// VGA timing recovery: samples an incoming hsync/vsync/blank_b stream,
// measures line and frame lengths against the nominal timing, reports
// lock and regenerates the pixel coordinates of the source.
module vga_timing_recovery #(
    parameter int HACTIVE     = 640,
    parameter int HFP         = 16,
    parameter int HSYN        = 96,
    parameter int HBP         = 48,
    parameter int VACTIVE     = 480,
    parameter int VFP         = 10,
    parameter int VSYN        = 2,
    parameter int VBP         = 33,
    parameter int LOCK_LINES  = 4,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        vgaclk,
    input  logic        reset,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        blank_b_in,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        pixel_valid,
    output logic        hlock,
    output logic        vlock,
    output logic        locked,
    output logic        sof,
    output logic [10:0] h_meas,
    output logic [10:0] v_meas,
    output logic        timing_err
);

    localparam int HMAX = HACTIVE + HFP + HSYN + HBP;
    localparam int VMAX = VACTIVE + VFP + VSYN + VBP;

    localparam logic [10:0] HMAX_C  = 11'(HMAX);
    localparam logic [10:0] VMAX_C  = 11'(VMAX);
    localparam logic [10:0] H_TMO   = 11'(2 * HMAX);
    localparam logic [10:0] V_TMO   = 11'(2 * VMAX);
    localparam logic [10:0] CNT_SAT = 11'h7FF;
    localparam logic [9:0]  X_LAST  = 10'(HMAX - 1);
    localparam logic [9:0]  Y_LAST  = 10'(VMAX - 1);
    localparam logic [9:0]  X_SYNC  = 10'(HACTIVE + HFP);
    localparam logic [9:0]  Y_SYNC  = 10'(VACTIVE + VFP);
    localparam logic [3:0]  H_LOCK_N = 4'(LOCK_LINES);
    localparam logic [3:0]  V_LOCK_N = 4'(LOCK_FRAMES);

    // stage-1 input registers and their one-cycle history
    logic        hs_q, vs_q, blank_b_q;
    logic        hs_prev, vs_prev;
    // measurement state
    logic [10:0] hcnt, vcnt;
    logic        h_first, v_first;
    logic [3:0]  h_match, v_match;

    // next-state values
    logic        hs_rise, vs_rise;
    logic [10:0] h_len;
    logic [10:0] hcnt_nxt, vcnt_nxt, h_meas_nxt, v_meas_nxt;
    logic        h_first_nxt, v_first_nxt;
    logic [3:0]  h_match_nxt, v_match_nxt;
    logic        hlock_nxt, vlock_nxt, locked_nxt;
    logic        h_err, v_err;
    logic [9:0]  x_nxt, y_nxt;

    // Edge detection, line/frame measurement, lock tracking and coordinate recovery.
    always_comb begin
        hs_rise     = hs_q & ~hs_prev;
        vs_rise     = vs_q & ~vs_prev;
        h_len       = (hcnt == CNT_SAT) ? CNT_SAT : hcnt + 11'd1;
        hcnt_nxt    = hcnt;
        h_first_nxt = h_first;
        h_meas_nxt  = h_meas;
        h_match_nxt = h_match;
        hlock_nxt   = hlock;
        h_err       = 1'b0;
        vcnt_nxt    = vcnt;
        v_first_nxt = v_first;
        v_meas_nxt  = v_meas;
        v_match_nxt = v_match;
        vlock_nxt   = vlock;
        v_err       = 1'b0;

        // horizontal: an edge always wins over a coincident timeout
        if (hs_rise) begin
            hcnt_nxt = 11'd0;
            if (!h_first) begin
                h_first_nxt = 1'b1;
            end else begin
                h_meas_nxt = h_len;
                if (h_len == HMAX_C) begin
                    h_match_nxt = (h_match == H_LOCK_N) ? h_match : h_match + 4'd1;
                    hlock_nxt   = (h_match_nxt == H_LOCK_N);
                end else begin
                    h_match_nxt = 4'd0;
                    hlock_nxt   = 1'b0;
                    h_err       = hlock;
                end
            end
        end else begin
            hcnt_nxt = (hcnt == CNT_SAT) ? CNT_SAT : hcnt + 11'd1;
            if (hcnt == H_TMO) begin
                h_match_nxt = 4'd0;
                hlock_nxt   = 1'b0;
                h_err       = hlock;
            end else begin
                h_match_nxt = h_match;
            end
        end

        // vertical: lines are counted on hsync edges
        if (vs_rise) begin
            vcnt_nxt = hs_rise ? 11'd1 : 11'd0;
            if (!v_first) begin
                v_first_nxt = 1'b1;
            end else begin
                v_meas_nxt = vcnt;
                if (vcnt == VMAX_C) begin
                    v_match_nxt = (v_match == V_LOCK_N) ? v_match : v_match + 4'd1;
                    vlock_nxt   = (v_match_nxt == V_LOCK_N);
                end else begin
                    v_match_nxt = 4'd0;
                    vlock_nxt   = 1'b0;
                    v_err       = vlock;
                end
            end
        end else begin
            if (hs_rise) begin
                vcnt_nxt = (vcnt == CNT_SAT) ? CNT_SAT : vcnt + 11'd1;
            end else begin
                vcnt_nxt = vcnt;
            end
            if (vcnt == V_TMO) begin
                v_match_nxt = 4'd0;
                vlock_nxt   = 1'b0;
                v_err       = vlock;
            end else begin
                v_match_nxt = v_match;
            end
        end

        // vertical lock is meaningless without horizontal lock
        if (!hlock_nxt) begin
            v_match_nxt = 4'd0;
            vlock_nxt   = 1'b0;
        end else begin
            v_match_nxt = v_match_nxt;
        end
        locked_nxt = hlock_nxt & vlock_nxt;

        // coordinates free-run and are re-anchored on sync edges
        if (hs_rise) begin
            x_nxt = X_SYNC;
        end else if (x == X_LAST) begin
            x_nxt = 10'd0;
        end else begin
            x_nxt = x + 10'd1;
        end

        if (vs_rise) begin
            y_nxt = Y_SYNC;
        end else if (x == X_LAST) begin
            y_nxt = (y == Y_LAST) ? 10'd0 : y + 10'd1;
        end else begin
            y_nxt = y;
        end
    end

    // State and registered outputs; reset clears everything asynchronously.
    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            blank_b_q   <= 1'b0;
            hs_prev     <= 1'b0;
            vs_prev     <= 1'b0;
            hcnt        <= 11'd0;
            vcnt        <= 11'd0;
            h_first     <= 1'b0;
            v_first     <= 1'b0;
            h_match     <= 4'd0;
            v_match     <= 4'd0;
            h_meas      <= 11'd0;
            v_meas      <= 11'd0;
            hlock       <= 1'b0;
            vlock       <= 1'b0;
            locked      <= 1'b0;
            timing_err  <= 1'b0;
            x           <= 10'd0;
            y           <= 10'd0;
            sof         <= 1'b0;
            pixel_valid <= 1'b0;
        end else begin
            hs_q        <= hsync_in;
            vs_q        <= vsync_in;
            blank_b_q   <= blank_b_in;
            hs_prev     <= hs_q;
            vs_prev     <= vs_q;
            hcnt        <= hcnt_nxt;
            vcnt        <= vcnt_nxt;
            h_first     <= h_first_nxt;
            v_first     <= v_first_nxt;
            h_match     <= h_match_nxt;
            v_match     <= v_match_nxt;
            h_meas      <= h_meas_nxt;
            v_meas      <= v_meas_nxt;
            hlock       <= hlock_nxt;
            vlock       <= vlock_nxt;
            locked      <= locked_nxt;
            timing_err  <= h_err | v_err;
            x           <= x_nxt;
            y           <= y_nxt;
            sof         <= (x_nxt == 10'd0) && (y_nxt == 10'd0) && locked_nxt;
            pixel_valid <= blank_b_in & locked_nxt;
        end
    end

endmodule

// File: tb/tb_vga_timing_recovery.sv
// Bench for vga_timing_recovery using a reduced 16x11 raster so whole
// frames fit in a short run. Stimulus pushes expectations into a
// cycle-ordered scoreboard; a monitor on the falling edge pops and checks.
module tb_vga_timing_recovery;

    localparam int HA = 8, HF = 2, HS = 3, HB = 3;
    localparam int VA = 6, VF = 1, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;   // 16
    localparam int VT = VA + VF + VS + VB;   // 11

    localparam int K_X = 0, K_Y = 1, K_PV = 2, K_HL = 3, K_VL = 4, K_LK = 5;
    localparam int K_SOF = 6, K_HM = 7, K_VM = 8, K_TE = 9, K_ALL0 = 10;

    logic        vgaclk = 1'b0;
    logic        reset;
    logic        hsync_in, vsync_in, blank_b_in;
    logic [9:0]  x, y;
    logic        pixel_valid, hlock, vlock, locked, sof, timing_err;
    logic [10:0] h_meas, v_meas;

    vga_timing_recovery #(
        .HACTIVE(HA), .HFP(HF), .HSYN(HS), .HBP(HB),
        .VACTIVE(VA), .VFP(VF), .VSYN(VS), .VBP(VB),
        .LOCK_LINES(4), .LOCK_FRAMES(2)
    ) dut (
        .vgaclk(vgaclk), .reset(reset),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_b_in(blank_b_in),
        .x(x), .y(y), .pixel_valid(pixel_valid),
        .hlock(hlock), .vlock(vlock), .locked(locked), .sof(sof),
        .h_meas(h_meas), .v_meas(v_meas), .timing_err(timing_err)
    );

    always #5 vgaclk = ~vgaclk;

    int cyc = 0;
    always @(posedge vgaclk) cyc <= cyc + 1;

    typedef struct {
        int at;
        int kind;
        int val;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    // source model state
    int sx = 0, sy = 0, vlen = VT;
    bit freeze = 1'b1, hs_kill = 1'b0, stretch_pending = 1'b0;
    int stretch_y = 0;
    bit prev_hs = 1'b0, prev_vs = 1'b0, hs_r = 1'b0, vs_r = 1'b0;
    int hs_k = 0, vs_k = 0, hs_tot = 0, vs_tot = 0, last_hs_cyc = 0;
    bit chk_lock = 1'b0, track = 1'b0, pv_zero = 1'b0, vgood = 1'b1;
    int exp_vmeas = VT;

    function automatic string kname(int k);
        case (k)
            K_X:    return "x";
            K_Y:    return "y";
            K_PV:   return "pixel_valid";
            K_HL:   return "hlock";
            K_VL:   return "vlock";
            K_LK:   return "locked";
            K_SOF:  return "sof";
            K_HM:   return "h_meas";
            K_VM:   return "v_meas";
            K_TE:   return "timing_err";
            K_ALL0: return "outputs_in_reset";
            default: return "unknown";
        endcase
    endfunction

    function automatic int actual(int k);
        case (k)
            K_X:    return int'(x);
            K_Y:    return int'(y);
            K_PV:   return int'(pixel_valid);
            K_HL:   return int'(hlock);
            K_VL:   return int'(vlock);
            K_LK:   return int'(locked);
            K_SOF:  return int'(sof);
            K_HM:   return int'(h_meas);
            K_VM:   return int'(v_meas);
            K_TE:   return int'(timing_err);
            K_ALL0: return ({x, y, pixel_valid, hlock, vlock, locked, sof,
                             h_meas, v_meas, timing_err} == 48'd0) ? 0 : 1;
            default: return -1;
        endcase
    endfunction

    function automatic void push(int kind, int at, int val);
        exp_t e;
        int i;
        e.at = at; e.kind = kind; e.val = val;
        i = 0;
        while (i < sb.size() && sb[i].at <= at) i++;
        sb.insert(i, e);
    endfunction

    // monitor: compare every expectation that has come due
    exp_t em;
    int   am;
    always @(negedge vgaclk) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            em = sb.pop_front();
            am = actual(em.kind);
            total = total + 1;
            if (em.at != cyc || am !== em.val) begin
                bad = bad + 1;
                $display("FAIL %s cyc=%0d due=%0d got=%0d want=%0d",
                         kname(em.kind), cyc, em.at, am, em.val);
            end
        end
    end

    task automatic drive();
        hsync_in   = (sx >= HA + HF) && (sx < HA + HF + HS) && !hs_kill;
        vsync_in   = (sy >= VA + VF) && (sy < VA + VF + VS);
        blank_b_in = (sx < HA) && (sy < VA);
    endtask

    // advance the source one pixel, detect pin edges, queue expectations
    task automatic step();
        int len;
        @(posedge vgaclk);
        #1;
        if (!freeze) begin
            len = (stretch_pending && sy == stretch_y) ? HT + 1 : HT;
            sx = sx + 1;
            if (sx == len) begin
                sx = 0;
                if (stretch_pending && sy == stretch_y) stretch_pending = 1'b0;
                sy = (sy + 1 == vlen) ? 0 : sy + 1;
            end
        end
        drive();
        hs_r = hsync_in && !prev_hs && !reset;
        vs_r = vsync_in && !prev_vs && !reset;
        prev_hs = reset ? 1'b0 : hsync_in;
        prev_vs = reset ? 1'b0 : vsync_in;
        if (hs_r) begin
            hs_k++; hs_tot++; last_hs_cyc = cyc;
        end
        if (vs_r) begin
            vs_k++; vs_tot++;
        end
        if (chk_lock && hs_r) begin
            if (hs_k == 1) push(K_HM, cyc + 2, 0);
            if (hs_k == 2) push(K_HM, cyc + 2, HT);
            if (hs_k == 4) push(K_HL, cyc + 2, 0);
            if (hs_k == 5) begin
                push(K_HL, cyc + 1, 0);
                push(K_HL, cyc + 2, 1);
            end
        end
        if (chk_lock && vs_r) begin
            if (vs_k == 1) push(K_VM, cyc + 2, 0);
            if (vs_k == 2) begin
                push(K_VM, cyc + 2, exp_vmeas);
                push(K_VL, cyc + 2, 0);
            end
            if (vs_k >= 3 && !vgood) push(K_VL, cyc + 2, 0);
            if (vs_k == 3 && vgood) begin
                push(K_VL, cyc + 1, 0);
                push(K_VL, cyc + 2, 1);
                push(K_LK, cyc + 1, 0);
                push(K_LK, cyc + 2, 1);
            end
        end
        if (track) begin
            push(K_X, cyc + 2, sx);
            push(K_Y, cyc + 2, sy);
            push(K_SOF, cyc + 2, (sx == 0 && sy == 0) ? 1 : 0);
            push(K_PV, cyc + 1, (sx < HA && sy < VA) ? 1 : 0);
            push(K_TE, cyc + 1, 0);
        end
        if (pv_zero) push(K_PV, cyc + 1, 0);
    endtask

    task automatic bound_fail(string what);
        total = total + 1;
        bad   = bad + 1;
        $display("FAIL wait_%s cyc=%0d got=timeout want=event", what, cyc);
    endtask

    task automatic run_hs(int n, int budget, string what);
        int start = hs_tot;
        int k = 0;
        while (hs_tot < start + n && k < budget) begin step(); k++; end
        if (hs_tot < start + n) bound_fail(what);
    endtask

    task automatic run_vs(int n, int budget, string what);
        int start = vs_tot;
        int k = 0;
        while (vs_tot < start + n && k < budget) begin step(); k++; end
        if (vs_tot < start + n) bound_fail(what);
    endtask

    task automatic run_pos(int px, int py, int budget, string what);
        int k = 0;
        step();
        while (!(sx == px && sy == py) && k < budget) begin step(); k++; end
        if (!(sx == px && sy == py)) bound_fail(what);
    endtask

    initial begin
        int n;
        int r;
        reset = 1'b1;
        drive();

        // 1: lock-up from reset, then exact coordinate tracking for two frames
        repeat (3) begin step(); push(K_ALL0, cyc, 0); end
        reset = 1'b0; freeze = 1'b0;
        hs_k = 0; vs_k = 0; chk_lock = 1'b1;
        run_vs(3, 5 * HT * VT, "scn1_vlock");
        run_pos(0, VA + VF + 1, 2 * HT * VT, "scn1_line");
        track = 1'b1;
        repeat (2 * HT * VT) step();
        track = 1'b0;
        repeat (4) step();

        // 2: one stretched line breaks lock, then recovery
        run_pos(0, 2, 2 * HT * VT, "scn2_start");
        stretch_pending = 1'b1; stretch_y = 2;
        run_hs(2, 4 * HT, "scn2_err");
        n = cyc;
        push(K_HL, n + 1, 1);
        push(K_TE, n + 1, 0);
        push(K_TE, n + 2, 1);
        push(K_TE, n + 3, 0);
        push(K_HL, n + 2, 0);
        push(K_VL, n + 2, 0);
        push(K_LK, n + 2, 0);
        push(K_HM, n + 2, HT + 1);
        run_hs(4, 6 * HT, "scn2_hlock");
        n = cyc;
        push(K_HL, n + 1, 0);
        push(K_HL, n + 2, 1);
        run_vs(1, 2 * HT * VT, "scn2_vs1");
        push(K_VL, cyc + 2, 0);
        run_vs(1, 2 * HT * VT, "scn2_vs2");
        n = cyc;
        push(K_VL, n + 1, 0);
        push(K_VL, n + 2, 1);
        push(K_LK, n + 2, 1);
        repeat (4) step();

        // 3: hsync held low until the line timeout fires
        run_pos(0, 1, 2 * HT * VT, "scn3_start");
        r = last_hs_cyc;
        hs_kill = 1'b1;
        push(K_HL, r + 34, 1);
        push(K_TE, r + 34, 0);
        push(K_TE, r + 35, 1);
        push(K_HL, r + 35, 0);
        push(K_HM, r + 35, HT);
        push(K_TE, r + 36, 0);
        repeat (50) step();
        hs_kill = 1'b0;
        repeat (4) step();

        // 4: reset mid-frame, relock from wherever the source is
        run_pos(5, 3, 2 * HT * VT, "scn4_start");
        reset = 1'b1;
        chk_lock = 1'b0;
        push(K_ALL0, cyc, 0);
        repeat (3) begin step(); push(K_ALL0, cyc, 0); end
        reset = 1'b0;
        hs_k = 0; vs_k = 0; chk_lock = 1'b1;
        run_vs(3, 5 * HT * VT, "scn4_vlock");
        repeat (4) step();

        // 5: source one line short per frame never gains vertical lock
        reset = 1'b1; chk_lock = 1'b0; freeze = 1'b1;
        sx = 0; sy = 0; vlen = VT - 1;
        drive();
        repeat (2) begin step(); push(K_ALL0, cyc, 0); end
        reset = 1'b0; freeze = 1'b0;
        hs_k = 0; vs_k = 0; exp_vmeas = VT - 1; vgood = 1'b0;
        pv_zero = 1'b1; chk_lock = 1'b1;
        run_vs(5, 7 * HT * VT, "scn5_frames");
        push(K_HL, cyc + 1, 1);
        pv_zero = 1'b0;
        repeat (4) step();

        if (sb.size() != 0) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
